// File: rtl/freq_duty_calc_if.sv
// rtl/freq_duty_calc_if.sv - measurement in / result out bundle for freq_duty_calc
//
// Purpose: groups the capture-side measurement strobe and the readout-side
// result signals of freq_duty_calc into one bundle.
//
// Signals:
//   meas_valid    capture -> calc   one-cycle strobe, period_in/high_in valid
//   period_in     capture -> calc   measured period in clk cycles
//   high_in       capture -> calc   measured high time in clk cycles
//   freq_hz       calc -> readout   CLOCK_FREQ / period, truncated
//   duty_pm       calc -> readout   high*DUTY_SCALE / period, clamped
//   result_valid  calc -> readout   one-cycle strobe, results updated
//   busy          calc -> readout   measurement in progress
//   div_err       calc -> readout   last result came from a zero period
//   drop_cnt      calc -> readout   saturating count of rejected strobes
//
// Modports: master = capture/readout side, slave = freq_duty_calc.

interface freq_duty_calc_if;
   logic        meas_valid;
   logic [31:0] period_in;
   logic [31:0] high_in;
   logic [31:0] freq_hz;
   logic [15:0] duty_pm;
   logic        result_valid;
   logic        busy;
   logic        div_err;
   logic [15:0] drop_cnt;

   modport master (
      output meas_valid, period_in, high_in,
      input  freq_hz, duty_pm, result_valid, busy, div_err, drop_cnt
   );

   modport slave (
      input  meas_valid, period_in, high_in,
      output freq_hz, duty_pm, result_valid, busy, div_err, drop_cnt
   );
endinterface

// File: rtl/freq_duty_calc.sv
// rtl/freq_duty_calc.sv - period/high-time to frequency and duty converter
//
// Purpose: takes each completed period/high-time measurement and converts it
// to a frequency in Hz and a duty cycle in DUTY_SCALE units using one shared
// 48-iteration restoring divider (frequency first, then duty).
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   freq_duty_calc_if.slave: meas_valid/period_in/high_in in,
//         freq_hz/duty_pm/result_valid/busy/div_err/drop_cnt out
//
// Parameters:
//   CLOCK_FREQ  system clock frequency in Hz (< 2^32)
//   DUTY_SCALE  duty resolution, 1000 = per-mille (< 2^16)

module freq_duty_calc #(
   parameter logic [31:0] CLOCK_FREQ = 32'd50000000,
   parameter logic [15:0] DUTY_SCALE = 16'd1000
) (
   input  logic            clk,
   input  logic            rst,
   freq_duty_calc_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_FREQ = 2'd1,
      DIV_DUTY = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t      state;

   // Operands latched on acceptance; untouched until the next IDLE accept.
   logic [31:0] period_r;
   logic [31:0] high_r;
   logic        err_path;

   // Divider state: dq starts as the dividend and fills with quotient bits
   // from the bottom as dividend bits leave from the top.
   logic [47:0] dq;
   logic [31:0] rem;
   logic [5:0]  iter;
   logic [31:0] freq_q;

   // Registered outputs.
   logic [31:0] freq_hz_r;
   logic [15:0] duty_pm_r;
   logic        result_valid_r;
   logic        busy_r;
   logic        div_err_r;
   logic [15:0] drop_cnt_r;

   // One restoring step. rem_sh is the 33-bit partial remainder; since the
   // true difference is always below the 32-bit divisor, a 32-bit subtract
   // gives the exact new remainder whenever the step restores nothing.
   logic [32:0] rem_sh;
   logic        q_bit;
   logic [31:0] rem_nxt;
   logic [47:0] dq_nxt;
   logic [47:0] duty_dvd;
   logic [15:0] duty_clamped;

   always_comb begin
      rem_sh  = {rem, dq[47]};
      q_bit   = rem_sh[32] | (rem_sh[31:0] >= period_r);
      rem_nxt = q_bit ? (rem_sh[31:0] - period_r) : rem_sh[31:0];
      dq_nxt  = {dq[46:0], q_bit};
   end

   // Full 48-bit product; 32 x 16 bits can never overflow it.
   assign duty_dvd = {16'd0, high_r} * {32'd0, DUTY_SCALE};

   // high > period yields a quotient above DUTY_SCALE; clamp it.
   assign duty_clamped = (dq > {32'd0, DUTY_SCALE}) ? DUTY_SCALE : dq[15:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         period_r       <= 32'd0;
         high_r         <= 32'd0;
         err_path       <= 1'b0;
         dq             <= 48'd0;
         rem            <= 32'd0;
         iter           <= 6'd0;
         freq_q         <= 32'd0;
         freq_hz_r      <= 32'd0;
         duty_pm_r      <= 16'd0;
         result_valid_r <= 1'b0;
         busy_r         <= 1'b0;
         div_err_r      <= 1'b0;
         drop_cnt_r     <= 16'd0;
      end else begin
         result_valid_r <= 1'b0;

         // Any strobe outside IDLE (including DONE) is rejected.
         if (bus.meas_valid && (state != IDLE) && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
         end

         case (state)
            IDLE: begin
               if (bus.meas_valid) begin
                  period_r <= bus.period_in;
                  high_r   <= bus.high_in;
                  busy_r   <= 1'b1;
                  if (bus.period_in == 32'd0) begin
                     err_path <= 1'b1;
                     state    <= DONE;
                  end else begin
                     err_path <= 1'b0;
                     dq       <= {16'd0, CLOCK_FREQ};
                     rem      <= 32'd0;
                     iter     <= 6'd0;
                     state    <= DIV_FREQ;
                  end
               end
            end

            DIV_FREQ: begin
               if (iter == 6'd47) begin
                  // Last frequency bit lands here; reload for the duty pass.
                  freq_q <= dq_nxt[31:0];
                  dq     <= duty_dvd;
                  rem    <= 32'd0;
                  iter   <= 6'd0;
                  state  <= DIV_DUTY;
               end else begin
                  dq   <= dq_nxt;
                  rem  <= rem_nxt;
                  iter <= iter + 6'd1;
               end
            end

            DIV_DUTY: begin
               dq   <= dq_nxt;
               rem  <= rem_nxt;
               iter <= iter + 6'd1;
               if (iter == 6'd47) begin
                  state <= DONE;
               end
            end

            DONE: begin
               result_valid_r <= 1'b1;
               busy_r         <= 1'b0;
               if (err_path) begin
                  freq_hz_r <= 32'd0;
                  duty_pm_r <= 16'd0;
                  div_err_r <= 1'b1;
               end else begin
                  freq_hz_r <= freq_q;
                  duty_pm_r <= duty_clamped;
                  div_err_r <= 1'b0;
               end
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.freq_hz      = freq_hz_r;
   assign bus.duty_pm      = duty_pm_r;
   assign bus.result_valid = result_valid_r;
   assign bus.busy         = busy_r;
   assign bus.div_err      = div_err_r;
   assign bus.drop_cnt     = drop_cnt_r;

endmodule

// File: tb/tb_freq_duty_calc.sv
// tb/tb_freq_duty_calc.sv - directed self-checking bench for freq_duty_calc

module tb_freq_duty_calc;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   freq_duty_calc_if bus_if ();

   freq_duty_calc #(
      .CLOCK_FREQ (32'd50000000),
      .DUTY_SCALE (16'd1000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called one step after an edge; the next edge is T0. Returns at T0+1.
   task automatic send(input logic [31:0] p, input logic [31:0] h);
      bus_if.period_in  = p;
      bus_if.high_in    = h;
      bus_if.meas_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.meas_valid = 1'b0;
   endtask

   // Cycles from T0 to the result_valid sample (-1 on timeout), plus how many
   // samples had busy wrong (high before the result, low in the result cycle).
   task automatic wait_result(output int cyc, output int busy_bad);
      cyc      = -1;
      busy_bad = (bus_if.busy !== 1'b1) ? 1 : 0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk);
         #1;
         if (bus_if.result_valid === 1'b1) begin
            if (bus_if.busy !== 1'b0) busy_bad++;
            cyc = c;
            break;
         end
         if (bus_if.busy !== 1'b1) busy_bad++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus_if.freq_hz !== 32'd0) begin errors++; $display("FAIL reset_freq: got %0d expected 0", bus_if.freq_hz); end
      checks++; if (bus_if.duty_pm !== 16'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", bus_if.duty_pm); end
      checks++; if (bus_if.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus_if.result_valid); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
      checks++; if (bus_if.div_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus_if.div_err); end
      checks++; if (bus_if.drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", bus_if.drop_cnt); end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_nominal;
      int cyc, bb;
      send(32'd50000, 32'd12500);
      checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL nom_busy_t0: got %b expected 1", bus_if.busy); end
      wait_result(cyc, bb);
      checks++; if (cyc !== 97) begin errors++; $display("FAIL nom_latency: got %0d expected 97", cyc); end
      checks++; if (bb !== 0) begin errors++; $display("FAIL nom_busy_profile: got %0d bad samples expected 0", bb); end
      checks++; if (bus_if.freq_hz !== 32'd1000) begin errors++; $display("FAIL nom_freq: got %0d expected 1000", bus_if.freq_hz); end
      checks++; if (bus_if.duty_pm !== 16'd250) begin errors++; $display("FAIL nom_duty: got %0d expected 250", bus_if.duty_pm); end
      checks++; if (bus_if.div_err !== 1'b0) begin errors++; $display("FAIL nom_err: got %b expected 0", bus_if.div_err); end
      @(posedge clk);
      #1;
      checks++; if (bus_if.result_valid !== 1'b0) begin errors++; $display("FAIL nom_valid_pulse: got %b expected 0", bus_if.result_valid); end
      checks++; if (bus_if.freq_hz !== 32'd1000) begin errors++; $display("FAIL nom_freq_hold: got %0d expected 1000", bus_if.freq_hz); end
   endtask

   task automatic test_truncation;
      int cyc, bb;
      send(32'd3, 32'd1);
      wait_result(cyc, bb);
      checks++; if (bus_if.freq_hz !== 32'd16666666) begin errors++; $display("FAIL trunc_freq: got %0d expected 16666666", bus_if.freq_hz); end
      checks++; if (bus_if.duty_pm !== 16'd333) begin errors++; $display("FAIL trunc_duty: got %0d expected 333", bus_if.duty_pm); end
      send(32'd1, 32'd1);
      wait_result(cyc, bb);
      checks++; if (bus_if.freq_hz !== 32'd50000000) begin errors++; $display("FAIL p1_freq: got %0d expected 50000000", bus_if.freq_hz); end
      checks++; if (bus_if.duty_pm !== 16'd1000) begin errors++; $display("FAIL p1_duty: got %0d expected 1000", bus_if.duty_pm); end
   endtask

   task automatic test_clamp_error;
      int cyc, bb;
      send(32'd100, 32'd150);
      wait_result(cyc, bb);
      checks++; if (bus_if.freq_hz !== 32'd500000) begin errors++; $display("FAIL clamp_freq: got %0d expected 500000", bus_if.freq_hz); end
      checks++; if (bus_if.duty_pm !== 16'd1000) begin errors++; $display("FAIL clamp_duty: got %0d expected 1000", bus_if.duty_pm); end
      send(32'd0, 32'd7);
      wait_result(cyc, bb);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", cyc); end
      checks++; if (bb !== 0) begin errors++; $display("FAIL zero_busy_profile: got %0d bad samples expected 0", bb); end
      checks++; if (bus_if.freq_hz !== 32'd0) begin errors++; $display("FAIL zero_freq: got %0d expected 0", bus_if.freq_hz); end
      checks++; if (bus_if.duty_pm !== 16'd0) begin errors++; $display("FAIL zero_duty: got %0d expected 0", bus_if.duty_pm); end
      checks++; if (bus_if.div_err !== 1'b1) begin errors++; $display("FAIL zero_err: got %b expected 1", bus_if.div_err); end
      send(32'd50000, 32'd12500);
      wait_result(cyc, bb);
      checks++; if (bus_if.div_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", bus_if.div_err); end
      checks++; if (bus_if.freq_hz !== 32'd1000) begin errors++; $display("FAIL err_clear_freq: got %0d expected 1000", bus_if.freq_hz); end
   endtask

   task automatic test_back_to_back;
      int cyc, bb, first;
      first = -1;
      send(32'd100, 32'd50);
      bus_if.period_in = 32'd0;
      bus_if.high_in   = 32'd0;
      for (int c = 1; c <= 150; c++) begin
         @(posedge clk);
         #1;
         if (bus_if.result_valid === 1'b1) begin
            first = c;
            break;
         end
         if (c == 96) begin
            checks++; if (bus_if.drop_cnt !== 16'd2) begin errors++; $display("FAIL ovr_drop2: got %0d expected 2", bus_if.drop_cnt); end
         end
         // Strobes at T10, T50 (mid-divide) and T97 (DONE) are all dropped.
         bus_if.meas_valid = (c == 9) || (c == 49) || (c == 96);
      end
      bus_if.meas_valid = 1'b0;
      checks++; if (first !== 97) begin errors++; $display("FAIL ovr_latency: got %0d expected 97", first); end
      checks++; if (bus_if.freq_hz !== 32'd500000) begin errors++; $display("FAIL ovr_freq: got %0d expected 500000", bus_if.freq_hz); end
      checks++; if (bus_if.duty_pm !== 16'd500) begin errors++; $display("FAIL ovr_duty: got %0d expected 500", bus_if.duty_pm); end
      checks++; if (bus_if.div_err !== 1'b0) begin errors++; $display("FAIL ovr_err: got %b expected 0", bus_if.div_err); end
      checks++; if (bus_if.drop_cnt !== 16'd3) begin errors++; $display("FAIL done_drop: got %0d expected 3", bus_if.drop_cnt); end
      // Strobe during the result_valid cycle must be accepted.
      send(32'd3, 32'd1);
      checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", bus_if.busy); end
      wait_result(cyc, bb);
      checks++; if (cyc !== 97) begin errors++; $display("FAIL b2b_latency: got %0d expected 97", cyc); end
      checks++; if (bus_if.freq_hz !== 32'd16666666) begin errors++; $display("FAIL b2b_freq: got %0d expected 16666666", bus_if.freq_hz); end
      checks++; if (bus_if.drop_cnt !== 16'd3) begin errors++; $display("FAIL b2b_drop: got %0d expected 3", bus_if.drop_cnt); end
   endtask

   task automatic test_drop_saturation;
      int idle_seen;
      idle_seen = 0;
      bus_if.period_in  = 32'd1;
      bus_if.high_in    = 32'd1;
      bus_if.meas_valid = 1'b1;
      repeat (67000) @(posedge clk);
      #1;
      bus_if.meas_valid = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #1;
         if (bus_if.busy === 1'b0) begin
            idle_seen = 1;
            break;
         end
      end
      checks++; if (idle_seen !== 1) begin errors++; $display("FAIL sat_idle: got %0d expected 1", idle_seen); end
      checks++; if (bus_if.drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_drop: got %h expected ffff", bus_if.drop_cnt); end
      checks++; if (bus_if.freq_hz !== 32'd50000000) begin errors++; $display("FAIL sat_freq: got %0d expected 50000000", bus_if.freq_hz); end
   endtask

   task automatic test_reset_mid;
      int cyc, bb, spurious;
      spurious = 0;
      send(32'd50000, 32'd12500);
      repeat (29) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      checks++; if (bus_if.freq_hz !== 32'd0) begin errors++; $display("FAIL mid_freq: got %0d expected 0", bus_if.freq_hz); end
      checks++; if (bus_if.duty_pm !== 16'd0) begin errors++; $display("FAIL mid_duty: got %0d expected 0", bus_if.duty_pm); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus_if.busy); end
      checks++; if (bus_if.drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_drop: got %0d expected 0", bus_if.drop_cnt); end
      checks++; if (bus_if.result_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus_if.result_valid); end
      checks++; if (bus_if.div_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", bus_if.div_err); end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 150; c++) begin
         @(posedge clk);
         #1;
         if (bus_if.result_valid === 1'b1) spurious++;
      end
      checks++; if (spurious !== 0) begin errors++; $display("FAIL mid_no_result: got %0d expected 0", spurious); end
      send(32'd25000, 32'd5000);
      wait_result(cyc, bb);
      checks++; if (cyc !== 97) begin errors++; $display("FAIL post_latency: got %0d expected 97", cyc); end
      checks++; if (bus_if.freq_hz !== 32'd2000) begin errors++; $display("FAIL post_freq: got %0d expected 2000", bus_if.freq_hz); end
      checks++; if (bus_if.duty_pm !== 16'd200) begin errors++; $display("FAIL post_duty: got %0d expected 200", bus_if.duty_pm); end
   endtask

   initial begin
      checks            = 0;
      errors            = 0;
      rst               = 1'b1;
      bus_if.meas_valid = 1'b0;
      bus_if.period_in  = 32'd0;
      bus_if.high_in    = 32'd0;
      test_reset;
      test_nominal;
      test_truncation;
      test_clamp_error;
      test_back_to_back;
      test_drop_saturation;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
